// File: rtl/alu_issue_pkg.sv
// Shared constants and state type for the ALU issue/writeback controller.
package alu_issue_pkg;

  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_SUB   = 3'd1;
  localparam logic [2:0] FN_AND   = 3'd2;
  localparam logic [2:0] FN_OR    = 3'd3;
  localparam logic [2:0] FN_NOR   = 3'd4;
  localparam logic [2:0] FN_XOR   = 3'd5;
  localparam logic [2:0] FN_SLT   = 3'd6;
  localparam logic [2:0] FN_PASSB = 3'd7;

  localparam logic [5:0] OP_RTYPE      = 6'b000000;
  localparam logic [2:0] OP_IMM_PREFIX = 3'b001;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x SIZE register file: rs/rt/debug read ports, one write port, r0 fixed at zero.
module alu_regfile #(
  parameter int SIZE  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  input  logic [4:0]      dbg_addr,
  output logic [SIZE-1:0] rs_data,
  output logic [SIZE-1:0] rt_data,
  output logic [SIZE-1:0] dbg_data,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [SIZE-1:0] wdata
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][SIZE-1:0] mem;
  logic [AW-1:0]              wa;

  // Upper address bits are dropped so out-of-range addresses alias.
  assign wa = waddr[AW-1:0];

  // mem[0] is never written, so it reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst)
      mem <= '0;
    else if (we && wa != '0)
      mem[wa] <= wdata;
  end

  assign rs_data  = mem[rs_addr[AW-1:0]];
  assign rt_data  = mem[rt_addr[AW-1:0]];
  assign dbg_data = mem[dbg_addr[AW-1:0]];

endmodule

// File: rtl/alu_issue_unit.sv
// Multi-cycle issue/writeback controller in front of a combinational ALU.
// Define ALU_ISSUE_IMM_EN to compile in I-type (sign-extended immediate) decode.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [2:0]      alu_func,
  input  logic [SIZE-1:0] alu_out,
  input  logic            alu_zero,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic            zero,
  output logic            illegal,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [SIZE-1:0] dbg_wdata,
  output logic [SIZE-1:0] dbg_rdata
);

  state_t          state, state_nx;
  logic [31:0]     instr_q;
  logic [4:0]      dest_q;
  logic            legal_q;
  logic [SIZE-1:0] alu_res_q;
  logic            alu_zero_q;

  logic [SIZE-1:0] rs_data, rt_data;
  logic            dec_legal;
  logic [2:0]      dec_func;
  logic [4:0]      dec_dest;
  logic [SIZE-1:0] dec_b;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [SIZE-1:0] rf_wdata;

  always_comb begin
    dec_legal = (instr_q[31:26] == OP_RTYPE);
    dec_func  = instr_q[2:0];
    dec_dest  = instr_q[15:11];
    dec_b     = rt_data;
`ifdef ALU_ISSUE_IMM_EN
    if (instr_q[31:29] == OP_IMM_PREFIX) begin
      dec_legal = 1'b1;
      dec_func  = instr_q[28:26];
      dec_dest  = instr_q[20:16];
      dec_b     = {{(SIZE-16){instr_q[15]}}, instr_q[15:0]};
    end
`endif
  end

`ifndef ALU_ISSUE_IMM_EN
  logic unused_instr;
  assign unused_instr = ^instr_q[10:3];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = (state == IDLE);
    case (state)
      IDLE:    if (instr_valid) state_nx = DECODE;
      DECODE:  state_nx = dec_legal ? EXEC : WB;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      dest_q     <= '0;
      legal_q    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      alu_res_q  <= '0;
      alu_zero_q <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && instr_valid)
        instr_q <= instr;
      // Operands stay put until the next DECODE so the ALU inputs are stable.
      if (state == DECODE) begin
        alu_a    <= rs_data;
        alu_b    <= dec_b;
        alu_func <= dec_func;
        dest_q   <= dec_dest;
        legal_q  <= dec_legal;
      end
      if (state == EXEC) begin
        alu_res_q  <= alu_out;
        alu_zero_q <= alu_zero;
      end
      if (state == WB) begin
        done    <= 1'b1;
        result  <= legal_q ? alu_res_q : '0;
        zero    <= legal_q & alu_zero_q;
        illegal <= ~legal_q;
      end
    end
  end

  // WB and debug writes live in disjoint states, so a simple mux suffices.
  always_comb begin
    rf_we    = (state == WB && legal_q) || (state == IDLE && dbg_we);
    rf_waddr = (state == WB) ? dest_q : dbg_addr;
    rf_wdata = (state == WB) ? alu_res_q : dbg_wdata;
  end

  alu_regfile #(.SIZE(SIZE), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (instr_q[25:21]),
    .rt_addr  (instr_q[20:16]),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_rdata),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata)
  );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU closing the alu_* loop.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst, instr_valid, instr_ready;
  logic [31:0]     instr;
  logic [SIZE-1:0] alu_a, alu_b, alu_out, result, dbg_wdata, dbg_rdata;
  logic [2:0]      alu_func;
  logic            alu_zero, done, zero, illegal, dbg_we;
  logic [4:0]      dbg_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.SIZE(SIZE), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_zero(alu_zero), .done(done), .result(result),
    .zero(zero), .illegal(illegal), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  always_comb begin
    alu_out = alu_b;
    case (alu_func)
      FN_ADD: alu_out = alu_a + alu_b;
      FN_SUB: alu_out = alu_a - alu_b;
      FN_AND: alu_out = alu_a & alu_b;
      FN_OR:  alu_out = alu_a | alu_b;
      FN_NOR: alu_out = ~(alu_a | alu_b);
      FN_XOR: alu_out = alu_a ^ alu_b;
      FN_SLT: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = alu_b;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [2:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {6'd0, s, t, d, 8'd0, fn};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
  endtask

  task automatic dbg_rd(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a; #1;
    d = dbg_rdata;
  endtask

  // Issues one word, holds junk on instr while busy, and checks retire latency.
  task automatic issue(input logic [31:0] w, input int exp_cyc, input string name);
    int cyc;
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_ready_idle: got %b want 1", name, instr_ready);
    end
    instr_valid = 1'b1; instr = w;
    tick();
    dbg_we = 1'b0;
    instr  = 32'hFFFF_FFFF;
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      n_err++; $display("FAIL %s_ready_busy: got %b want 0", name, instr_ready);
    end
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (done === 1'b1) begin cyc = c; break; end
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (cyc != exp_cyc) begin
      n_err++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({instr_ready, done, zero, illegal} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags: got %b want 1000", {instr_ready, done, zero, illegal});
    end
    n_cmp++;
    if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++;
    if ({alu_a, alu_b, alu_func} !== '0) begin
      n_err++; $display("FAIL reset_alu_ops: got %h %h %h want 0", alu_a, alu_b, alu_func);
    end
    for (int r = 0; r < 32; r++) begin
      dbg_rd(5'(r), d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL reset_r%0d: got %h want 0", r, d); end
    end
  endtask

  task automatic test_add();
    logic [31:0] d;
    dbg_wr(5'd1, 32'd5);
    dbg_wr(5'd2, 32'd7);
    issue(rtype(1, 2, 3, FN_ADD), 3, "add");
    n_cmp++;
    if ({result, zero, illegal} !== {32'd12, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL add_result: got %h z%b i%b want 0000000c z0 i0", result, zero, illegal);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_func} !== {32'd5, 32'd7, FN_ADD}) begin
      n_err++; $display("FAIL add_alu_hold: got %h %h %h want 5 7 0", alu_a, alu_b, alu_func);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: got %b want 0", done); end
    dbg_rd(5'd3, d);
    n_cmp++;
    if (d !== 32'd12) begin n_err++; $display("FAIL add_r3: got %h want 0000000c", d); end
  endtask

  task automatic test_sub_slt();
    logic [31:0] d;
    dbg_wr(5'd2, 32'd5);
    dbg_wr(5'd4, 32'h55);
    issue(rtype(4, 2, 4, FN_SUB), 3, "sub");
    issue(rtype(1, 2, 4, FN_SUB), 3, "sub");
    n_cmp++;
    if ({result, zero} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL sub_result: got %h z%b want 0 z1", result, zero);
    end
    dbg_rd(5'd4, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL sub_r4: got %h want 0", d); end
    dbg_wr(5'd6, 32'd9);
    issue(rtype(1, 6, 5, FN_SLT), 3, "slt");
    n_cmp++;
    if ({result, zero} !== {32'd1, 1'b0}) begin
      n_err++; $display("FAIL slt_true: got %h z%b want 1 z0", result, zero);
    end
    dbg_rd(5'd5, d);
    n_cmp++;
    if (d !== 32'd1) begin n_err++; $display("FAIL slt_r5: got %h want 1", d); end
    issue(rtype(6, 1, 5, FN_SLT), 3, "slt_rev");
    n_cmp++;
    if ({result, zero} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL slt_false: got %h z%b want 0 z1", result, zero);
    end
  endtask

  task automatic test_r0_write();
    logic [31:0] d;
    dbg_wr(5'd2, 32'd8);
    issue(rtype(1, 2, 0, FN_NOR), 3, "nor_r0");
    n_cmp++;
    if (result !== 32'hFFFF_FFF2) begin
      n_err++; $display("FAIL nor_result: got %h want fffffff2", result);
    end
    dbg_rd(5'd0, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL nor_r0: got %h want 0", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    issue({6'b111111, 5'd1, 5'd2, 5'd3, 8'd0, FN_ADD}, 2, "illegal");
    n_cmp++;
    if ({result, zero, illegal} !== {32'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL illegal_flags: got %h z%b i%b want 0 z0 i1", result, zero, illegal);
    end
    dbg_rd(5'd3, d);
    n_cmp++;
    if (d !== 32'd12) begin n_err++; $display("FAIL illegal_r3: got %h want 0000000c", d); end
  endtask

  task automatic test_itype();
    logic [31:0] d;
    logic [31:0] w;
    w = {6'b001000, 5'd0, 5'd7, 16'hFFFF};
`ifdef ALU_ISSUE_IMM_EN
    issue(w, 3, "addi");
    n_cmp++;
    if ({result, illegal} !== {32'hFFFF_FFFF, 1'b0}) begin
      n_err++; $display("FAIL addi_result: got %h i%b want ffffffff i0", result, illegal);
    end
    dbg_rd(5'd7, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addi_r7: got %h want ffffffff", d); end
`else
    issue(w, 2, "addi_off");
    n_cmp++;
    if ({result, illegal} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL addi_off_flags: got %h i%b want 0 i1", result, illegal);
    end
    dbg_rd(5'd7, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL addi_off_r7: got %h want 0", d); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    issue(rtype(3, 3, 8, FN_ADD), 3, "b2b_first");
    issue(rtype(8, 1, 9, FN_ADD), 3, "b2b_second");
    n_cmp++;
    if ({result, illegal} !== {32'd29, 1'b0}) begin
      n_err++; $display("FAIL b2b_result: got %h i%b want 0000001d i0", result, illegal);
    end
    dbg_rd(5'd9, d);
    n_cmp++;
    if (d !== 32'd29) begin n_err++; $display("FAIL b2b_r9: got %h want 0000001d", d); end
  endtask

  task automatic test_dbg_same_edge();
    dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'd100;
    issue(rtype(10, 1, 11, FN_ADD), 3, "dbg_same_edge");
    n_cmp++;
    if (result !== 32'd105) begin
      n_err++; $display("FAIL dbg_same_edge_result: got %h want 00000069", result);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        seen;
    instr_valid = 1'b1; instr = rtype(1, 2, 3, FN_ADD);
    tick();
    instr_valid = 1'b0;
    tick();
    n_cmp++;
    if (alu_a !== 32'd5) begin n_err++; $display("FAIL mid_exec_a: got %h want 5", alu_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({instr_ready, done, result} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++; $display("FAIL mid_reset_state: got r%b d%b %h want r1 d0 0", instr_ready, done, result);
    end
    dbg_rd(5'd3, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL mid_reset_r3: got %h want 0", d); end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen = seen | done;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL mid_reset_done: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_r0_write();
    test_illegal();
    test_itype();
    test_back_to_back();
    test_dbg_same_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
